// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: request, capture, hold under stall, issue one PC strobe.
// Issue latency is 2 cycles after mem_ack with stall low; stall only holds the captured word in HOLD.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_address,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        ins_count,
  output logic        jump_enable,
  output logic        return_enable,
  output logic [15:0] jump_address,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    ISSUE = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  localparam logic [3:0] OP_JMP    = 4'hE;
  localparam logic [3:0] OP_RET    = 4'hF;

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic       link_valid;
  logic       timeout;
  logic       is_jmp;
  logic       is_ret;

  assign timeout = (wait_cnt == WAIT_LAST) && !mem_ack;
  assign is_jmp  = (instr[15:12] == OP_JMP);
  assign is_ret  = (instr[15:12] == OP_RET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mem_ack wins over an expiring wait counter on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH: begin
        if (mem_ack) begin
          state_next = HOLD;
        end else if (timeout) begin
          state_next = FAULT;
        end
      end
      HOLD:    if (!stall) state_next = ISSUE;
      ISSUE:   state_next = FETCH;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (state != FETCH) begin
      wait_cnt <= 4'd0;
    end else if (!mem_ack && !timeout) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= 16'h0000;
    end else if (state == FETCH && mem_ack) begin
      instr <= mem_rdata;
    end
  end

  // A RET without a live link issues as sequential and leaves the link alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_valid <= 1'b0;
    end else if (state == ISSUE) begin
      if (is_jmp) begin
        link_valid <= 1'b1;
      end else if (is_ret) begin
        link_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_addr      = pc_address;
    instr_valid   = 1'b0;
    ins_count     = 1'b0;
    jump_enable   = 1'b0;
    return_enable = 1'b0;
    jump_address  = 16'h0000;
    fault         = 1'b0;
    case (state)
      FETCH: mem_req = 1'b1;
      HOLD:  instr_valid = 1'b1;
      ISSUE: begin
        instr_valid   = 1'b1;
        ins_count     = 1'b1;
        jump_enable   = is_jmp;
        return_enable = is_ret && link_valid;
        if (is_jmp) begin
          jump_address = {4'b0000, instr[11:0]};
        end
      end
      FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_address;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        ins_count;
  logic        jump_enable;
  logic        return_enable;
  logic [15:0] jump_address;
  logic        fault;

  int checks   = 0;
  int failures = 0;
  bit link_model = 1'b0;

  fetch_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_address    (pc_address),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .ins_count     (ins_count),
    .jump_enable   (jump_enable),
    .return_enable (return_enable),
    .jump_address  (jump_address),
    .fault         (fault)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge; leaves the DUT in its first FETCH cycle.
  task automatic apply_reset();
    reset   = 1'b1;
    mem_ack = 1'b0;
    stall   = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_ins_count", ins_count, 0);
    check("rst_jump_enable", jump_enable, 0);
    check("rst_return_enable", return_enable, 0);
    check("rst_jump_address", jump_address, 0);
    check("rst_fault", fault, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rel_cycle1_idle", mem_req, 0);
    check("rel_cycle1_jump", jump_enable, 0);
    @(negedge clk);
    check("rel_cycle2_fetch", mem_req, 1);
    check("rel_cycle2_addr", mem_addr, pc_address);
    link_model = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One instruction: ack after lat idle FETCH cycles, stall high for stall_len
  // cycles counted from the ack cycle, then expect a single issue.
  task automatic do_fetch(input logic [15:0] data, input int lat, input int stall_len);
    bit ok;
    int req_cycles;
    int valid_cycles;
    int pulses;
    int stray;
    int exp_valid;
    bit exp_j;
    bit exp_r;
    wait_req(ok);
    check("req_seen", ok, 1);
    if (!ok) return;
    check("fetch_addr", mem_addr, pc_address);
    req_cycles = 0;
    for (int i = 0; i < lat; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      mem_ack = 1'b0;
      @(negedge clk);
    end
    if (mem_req === 1'b1) req_cycles++;
    mem_ack   = 1'b1;
    mem_rdata = data;
    stall     = (stall_len > 0);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    exp_j = (data[15:12] == 4'hE);
    exp_r = (data[15:12] == 4'hF) && link_model;
    exp_valid = ((stall_len > 1) ? stall_len - 1 : 0) + 2;
    valid_cycles = 0;
    pulses = 0;
    stray = 0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (instr_valid === 1'b1) valid_cycles++;
      if (ins_count === 1'b1) begin
        pulses++;
        break;
      end
      if (jump_enable !== 1'b0 || return_enable !== 1'b0) stray++;
      stall = (cyc < stall_len);
      @(negedge clk);
    end
    check("issue_pulse", pulses, 1);
    check("req_cycles", req_cycles, lat + 1);
    check("valid_cycles", valid_cycles, exp_valid);
    check("stray_strobe", stray, 0);
    check("instr", instr, data);
    check("jump_enable", jump_enable, exp_j);
    check("jump_address", jump_address, exp_j ? {4'h0, data[11:0]} : 16'h0000);
    check("return_enable", return_enable, exp_r);
    check("no_fault", fault, 0);
    if (exp_j) link_model = 1'b1;
    else if (exp_r) link_model = 1'b0;
    stall      = 1'($urandom);
    pc_address = 16'($urandom);
    @(negedge clk);
    check("single_pulse", ins_count, 0);
    check("refetch_req", mem_req, 1);
    check("refetch_addr", mem_addr, pc_address);
    check("post_issue_valid", instr_valid, 0);
  endtask

  initial begin
    int n;
    bit ok;
    logic [15:0] d;
    reset = 1'b1;
    pc_address = 16'h0000;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    stall = 1'b0;
    apply_reset();

    do_fetch(16'hF000, 1, 0);
    do_fetch(16'h1234, 1, 0);
    do_fetch(16'hE0A5, 2, 0);
    do_fetch(16'hF000, 0, 0);
    do_fetch(16'hF000, 0, 0);
    do_fetch(16'h5A5A, 1, 5);
    do_fetch(16'h0BCD, TIMEOUT - 1, 0);

    for (int k = 0; k < 40; k++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d[15:12] = 4'hE;
        1: d[15:12] = 4'hF;
        default: ;
      endcase
      do_fetch(d, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 4));
    end

    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      mem_ack = 1'b0;
      @(negedge clk);
    end
    check("timeout_cycles", n, TIMEOUT);
    check("fault_set", fault, 1);
    check("fault_req", mem_req, 0);
    mem_ack = 1'b1;
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("fault_sticky", fault, 1);
    check("fault_ignores_ack", mem_req, 0);
    check("fault_no_valid", instr_valid, 0);
    check("fault_no_issue", ins_count, 0);
    apply_reset();
    apply_reset();

    wait_req(ok);
    check("hold_req_seen", ok, 1);
    mem_ack = 1'b1;
    mem_rdata = 16'hE0FF;
    stall = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("hold_instr", instr, 16'hE0FF);
    check("hold_valid", instr_valid, 1);
    apply_reset();
    do_fetch(16'hF000, 1, 0);
    do_fetch(16'hE123, 0, 1);
    do_fetch(16'hF456, 3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
